// File: rtl/pippo_timer_intc.sv
// Timer interrupt sequencer: edge-captured WD/PIT/FIT pending bits, fixed-priority exception requests, and watchdog reset pulses.
// Optional nested watchdog-over-PIT/FIT handling is enabled by defining PIPPO_TIMER_CRIT_NEST_EN.
module pippo_timer_intc #(
    parameter int RST_PULSE = 16,
    parameter int RST_CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_watchdog,
    input  logic       sig_pit,
    input  logic       sig_fit,
    input  logic       rqt_core_rst,
    input  logic       rqt_sys_rst,
    input  logic       rqt_chip_rst,
    input  logic       msr_ce,
    input  logic       msr_ee,
    input  logic       except_ack,
    input  logic       except_done,
    output logic       except_req,
    output logic [1:0] except_code,
    output logic [2:0] pending,
    output logic       rst_core_o,
    output logic       rst_sys_o,
    output logic       rst_chip_o,
    output logic       busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_RST  = 2'd3;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_WD   = 2'b01;
    localparam logic [1:0] C_PIT  = 2'b10;
    localparam logic [1:0] C_FIT  = 2'b11;

    logic [1:0]        state_reg, state_next;
    logic [2:0]        sig_q_reg;
    logic [2:0]        pending_reg, pending_next;
    logic              req_reg, req_next;
    logic [1:0]        code_reg, code_next;
    logic [2:0]        sel_reg, sel_next;
    logic [RST_CW-1:0] cnt_reg, cnt_next;
`ifdef PIPPO_TIMER_CRIT_NEST_EN
    logic              nest_reg, nest_next;
    logic [1:0]        active_reg, active_next;
    logic [1:0]        outer_reg, outer_next;
`endif

    logic [2:0] sig_now, rise, eligible, clr_mask, code_mask;
    logic [1:0] winner;
    logic       rqt_any, code_en, clear_all, enter_rst;

    assign sig_now  = {sig_watchdog, sig_pit, sig_fit};
    assign rise     = sig_now & ~sig_q_reg;
    assign eligible = {pending_reg[2] & msr_ce, pending_reg[1] & msr_ee, pending_reg[0] & msr_ee};
    assign winner   = eligible[2] ? C_WD : eligible[1] ? C_PIT : eligible[0] ? C_FIT : C_NONE;
    assign rqt_any  = rqt_core_rst | rqt_sys_rst | rqt_chip_rst;
    assign code_en  = (code_reg == C_WD) ? msr_ce : msr_ee;

    always_comb begin
        case (code_reg)
            C_WD:    code_mask = 3'b100;
            C_PIT:   code_mask = 3'b010;
            C_FIT:   code_mask = 3'b001;
            default: code_mask = 3'b000;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        code_next  = code_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        clr_mask   = 3'b000;
        clear_all  = 1'b0;
        enter_rst  = 1'b0;
`ifdef PIPPO_TIMER_CRIT_NEST_EN
        nest_next   = nest_reg;
        active_next = active_reg;
        outer_next  = outer_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (rqt_any) begin
                    enter_rst = 1'b1;
                end else if (|eligible) begin
                    state_next = S_REQ;
                    req_next   = 1'b1;
                    code_next  = winner;
                end
            end
            S_REQ: begin
                if (rqt_any) begin
                    enter_rst = 1'b1;
                end else if (except_ack) begin
                    state_next = S_BUSY;
                    req_next   = 1'b0;
                    code_next  = C_NONE;
                    clr_mask   = code_mask;
`ifdef PIPPO_TIMER_CRIT_NEST_EN
                    active_next = code_reg;
`endif
                end else if (!code_en) begin
                    // Withdrawn request keeps its pending bit for a later retry.
                    req_next  = 1'b0;
                    code_next = C_NONE;
`ifdef PIPPO_TIMER_CRIT_NEST_EN
                    state_next = nest_reg ? S_BUSY : S_IDLE;
                    nest_next  = 1'b0;
`else
                    state_next = S_IDLE;
`endif
                end
            end
            S_BUSY: begin
                if (rqt_any) begin
                    enter_rst = 1'b1;
                end else if (except_done) begin
`ifdef PIPPO_TIMER_CRIT_NEST_EN
                    if (nest_reg) begin
                        nest_next   = 1'b0;
                        active_next = outer_reg;
                    end else begin
                        state_next  = S_IDLE;
                        active_next = C_NONE;
                    end
`else
                    state_next = S_IDLE;
`endif
                end
`ifdef PIPPO_TIMER_CRIT_NEST_EN
                else if (!nest_reg && active_reg != C_WD && eligible[2]) begin
                    state_next = S_REQ;
                    req_next   = 1'b1;
                    code_next  = C_WD;
                    nest_next  = 1'b1;
                    outer_next = active_reg;
                end
`endif
            end
            default: begin
                if (cnt_reg == '0) begin
                    state_next = S_IDLE;
                    sel_next   = 3'b000;
                    clear_all  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
        endcase
        if (enter_rst) begin
            state_next = S_RST;
            req_next   = 1'b0;
            code_next  = C_NONE;
            cnt_next   = RST_CW'(RST_PULSE - 1);
            sel_next   = rqt_chip_rst ? 3'b100 : rqt_sys_rst ? 3'b010 : 3'b001;
`ifdef PIPPO_TIMER_CRIT_NEST_EN
            nest_next   = 1'b0;
            active_next = C_NONE;
`endif
        end
        // A fresh edge on the ack cycle wins over the clear.
        pending_next = clear_all ? 3'b000 : ((pending_reg & ~clr_mask) | rise);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            sig_q_reg   <= 3'b000;
            pending_reg <= 3'b000;
            req_reg     <= 1'b0;
            code_reg    <= C_NONE;
            sel_reg     <= 3'b000;
            cnt_reg     <= '0;
`ifdef PIPPO_TIMER_CRIT_NEST_EN
            nest_reg    <= 1'b0;
            active_reg  <= C_NONE;
            outer_reg   <= C_NONE;
`endif
        end else begin
            state_reg   <= state_next;
            sig_q_reg   <= sig_now;
            pending_reg <= pending_next;
            req_reg     <= req_next;
            code_reg    <= code_next;
            sel_reg     <= sel_next;
            cnt_reg     <= cnt_next;
`ifdef PIPPO_TIMER_CRIT_NEST_EN
            nest_reg    <= nest_next;
            active_reg  <= active_next;
            outer_reg   <= outer_next;
`endif
        end
    end

    assign except_req  = req_reg;
    assign except_code = code_reg;
    assign pending     = pending_reg;
    assign rst_chip_o  = sel_reg[2];
    assign rst_sys_o   = sel_reg[1];
    assign rst_core_o  = sel_reg[0];
    assign busy        = (state_reg == S_BUSY);
endmodule

// File: tb/tb_pippo_timer_intc.sv
// Directed bench for pippo_timer_intc: one task per scenario, inline checks, single summary line.
module tb_pippo_timer_intc;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sig_watchdog = 1'b0, sig_pit = 1'b0, sig_fit = 1'b0;
    logic       rqt_core_rst = 1'b0, rqt_sys_rst = 1'b0, rqt_chip_rst = 1'b0;
    logic       msr_ce = 1'b0, msr_ee = 1'b0;
    logic       except_ack = 1'b0, except_done = 1'b0;
    logic       except_req;
    logic [1:0] except_code;
    logic [2:0] pending;
    logic       rst_core_o, rst_sys_o, rst_chip_o, busy;

    int total = 0;
    int bad   = 0;

    pippo_timer_intc #(.RST_PULSE(16), .RST_CW(8)) dut (
        .clk(clk), .rst(rst),
        .sig_watchdog(sig_watchdog), .sig_pit(sig_pit), .sig_fit(sig_fit),
        .rqt_core_rst(rqt_core_rst), .rqt_sys_rst(rqt_sys_rst), .rqt_chip_rst(rqt_chip_rst),
        .msr_ce(msr_ce), .msr_ee(msr_ee),
        .except_ack(except_ack), .except_done(except_done),
        .except_req(except_req), .except_code(except_code), .pending(pending),
        .rst_core_o(rst_core_o), .rst_sys_o(rst_sys_o), .rst_chip_o(rst_chip_o), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change just after a falling edge; outputs are sampled on falling edges.
    task automatic pulse_ack();
        except_ack = 1'b1;
        @(negedge clk);
        except_ack = 1'b0;
    endtask

    task automatic pulse_done();
        except_done = 1'b1;
        @(negedge clk);
        except_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({except_req, except_code, pending, rst_core_o, rst_sys_o, rst_chip_o, busy} !== 10'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b",
                     {except_req, except_code, pending, rst_core_o, rst_sys_o, rst_chip_o, busy}, 10'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({except_req, pending, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", {except_req, pending, busy}, 5'b0);
        end
        $display("test_reset: done");
    endtask

    task automatic test_pit_level();
        int reqs;
        msr_ee = 1'b1;
        msr_ce = 1'b0;
        sig_pit = 1'b1;
        @(negedge clk);
        total++;
        if (pending !== 3'b010 || except_req !== 1'b0) begin
            bad++;
            $display("FAIL pit_pending got=%b/%b want=010/0", pending, except_req);
        end
        @(negedge clk);
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b10) begin
            bad++;
            $display("FAIL pit_req got=%b/%b want=1/10", except_req, except_code);
        end
        repeat (3) @(negedge clk);
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b10) begin
            bad++;
            $display("FAIL pit_req_hold got=%b/%b want=1/10", except_req, except_code);
        end
        pulse_ack();
        total++;
        if (pending !== 3'b000 || except_req !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pit_ack got=pend %b req %b busy %b want=000 0 1", pending, except_req, busy);
        end
        pulse_done();
        reqs = 0;
        for (int i = 0; i < 590; i++) begin
            if (except_req === 1'b1 || pending !== 3'b000) reqs++;
            @(negedge clk);
        end
        total++;
        if (reqs !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL pit_single got=extra %0d busy %b want=0 0", reqs, busy);
        end
        sig_pit = 1'b0;
        @(negedge clk);
        $display("test_pit_level: done");
    endtask

    task automatic test_wd_fit();
        msr_ce = 1'b1;
        msr_ee = 1'b1;
        sig_watchdog = 1'b1;
        sig_fit = 1'b1;
        @(negedge clk);
        total++;
        if (pending !== 3'b101) begin
            bad++;
            $display("FAIL wdfit_pending got=%b want=101", pending);
        end
        @(negedge clk);
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b01) begin
            bad++;
            $display("FAIL wdfit_first got=%b/%b want=1/01", except_req, except_code);
        end
        pulse_ack();
        total++;
        if (pending !== 3'b001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL wdfit_ack1 got=%b/%b want=001/1", pending, busy);
        end
        pulse_done();
        total++;
        if (busy !== 1'b0 || except_req !== 1'b0) begin
            bad++;
            $display("FAIL wdfit_idle got=%b/%b want=0/0", busy, except_req);
        end
        @(negedge clk);
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b11) begin
            bad++;
            $display("FAIL wdfit_second got=%b/%b want=1/11", except_req, except_code);
        end
        pulse_ack();
        pulse_done();
        total++;
        if (pending !== 3'b000 || busy !== 1'b0 || except_req !== 1'b0) begin
            bad++;
            $display("FAIL wdfit_end got=%b/%b/%b want=000/0/0", pending, busy, except_req);
        end
        sig_watchdog = 1'b0;
        sig_fit = 1'b0;
        @(negedge clk);
        $display("test_wd_fit: done");
    endtask

    task automatic test_gating();
        msr_ce = 1'b0;
        msr_ee = 1'b1;
        sig_watchdog = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (except_req !== 1'b0 || pending !== 3'b100) begin
            bad++;
            $display("FAIL gate_blocked got=%b/%b want=0/100", except_req, pending);
        end
        msr_ce = 1'b1;
        @(negedge clk);
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b01) begin
            bad++;
            $display("FAIL gate_open got=%b/%b want=1/01", except_req, except_code);
        end
        msr_ce = 1'b0;
        @(negedge clk);
        total++;
        if (except_req !== 1'b0 || pending !== 3'b100 || busy !== 1'b0) begin
            bad++;
            $display("FAIL gate_withdraw got=%b/%b/%b want=0/100/0", except_req, pending, busy);
        end
        msr_ce = 1'b1;
        @(negedge clk);
        pulse_ack();
        pulse_done();
        total++;
        if (pending !== 3'b000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL gate_end got=%b/%b want=000/0", pending, busy);
        end
        sig_watchdog = 1'b0;
        @(negedge clk);
        $display("test_gating: done");
    endtask

    task automatic test_rst_req();
        int width;
        bit core_seen;
        msr_ee = 1'b1;
        sig_pit = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b10) begin
            bad++;
            $display("FAIL rst_pre_req got=%b/%b want=1/10", except_req, except_code);
        end
        rqt_sys_rst = 1'b1;
        rqt_core_rst = 1'b1;
        @(negedge clk);
        total++;
        if (except_req !== 1'b0 || rst_sys_o !== 1'b1 || rst_core_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_entry got=req %b sys %b core %b want=0 1 0", except_req, rst_sys_o, rst_core_o);
        end
        width = 0;
        core_seen = 1'b0;
        while (rst_sys_o === 1'b1 && width < 100) begin
            width++;
            if (rst_core_o !== 1'b0 || rst_chip_o !== 1'b0) core_seen = 1'b1;
            if (width == 3) begin
                rqt_sys_rst = 1'b0;
                rqt_core_rst = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (width !== 16 || core_seen !== 1'b0) begin
            bad++;
            $display("FAIL rst_pulse got=width %0d other %b want=16 0", width, core_seen);
        end
        total++;
        if (pending !== 3'b000 || busy !== 1'b0 || except_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_exit got=%b/%b/%b want=000/0/0", pending, busy, except_req);
        end
        repeat (2) @(negedge clk);
        total++;
        if (except_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle got=%b want=0", except_req);
        end
        sig_pit = 1'b0;
        @(negedge clk);
        $display("test_rst_req: width=%0d", width);
    endtask

    task automatic test_nest();
        msr_ce = 1'b1;
        msr_ee = 1'b1;
        sig_fit = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b11) begin
            bad++;
            $display("FAIL nest_fit_req got=%b/%b want=1/11", except_req, except_code);
        end
        pulse_ack();
        sig_watchdog = 1'b1;
        @(negedge clk);
        total++;
        if (pending !== 3'b100) begin
            bad++;
            $display("FAIL nest_wd_pending got=%b want=100", pending);
        end
        @(negedge clk);
`ifdef PIPPO_TIMER_CRIT_NEST_EN
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b01) begin
            bad++;
            $display("FAIL nest_wd_req got=%b/%b want=1/01", except_req, except_code);
        end
        pulse_ack();
        pulse_done();
        total++;
        if (busy !== 1'b1 || except_req !== 1'b0) begin
            bad++;
            $display("FAIL nest_first_done got=%b/%b want=1/0", busy, except_req);
        end
        pulse_done();
        total++;
        if (busy !== 1'b0 || except_req !== 1'b0 || pending !== 3'b000) begin
            bad++;
            $display("FAIL nest_second_done got=%b/%b/%b want=0/0/000", busy, except_req, pending);
        end
`else
        repeat (3) @(negedge clk);
        total++;
        if (except_req !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL nest_blocked got=%b/%b want=0/1", except_req, busy);
        end
        pulse_done();
        total++;
        if (busy !== 1'b0 || except_req !== 1'b0) begin
            bad++;
            $display("FAIL nest_done_idle got=%b/%b want=0/0", busy, except_req);
        end
        @(negedge clk);
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b01) begin
            bad++;
            $display("FAIL nest_late_req got=%b/%b want=1/01", except_req, except_code);
        end
        pulse_ack();
        pulse_done();
`endif
        sig_fit = 1'b0;
        sig_watchdog = 1'b0;
        @(negedge clk);
        $display("test_nest: done");
    endtask

    task automatic test_async_abort();
        rqt_chip_rst = 1'b1;
        rqt_sys_rst = 1'b1;
        @(negedge clk);
        rqt_chip_rst = 1'b0;
        rqt_sys_rst = 1'b0;
        total++;
        if (rst_chip_o !== 1'b1 || rst_sys_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_chip got=chip %b sys %b want=1 0", rst_chip_o, rst_sys_o);
        end
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({except_req, except_code, pending, rst_core_o, rst_sys_o, rst_chip_o, busy} !== 10'b0) begin
            bad++;
            $display("FAIL abort_async got=%b want=%b",
                     {except_req, except_code, pending, rst_core_o, rst_sys_o, rst_chip_o, busy}, 10'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        msr_ee = 1'b1;
        sig_fit = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (except_req !== 1'b1 || except_code !== 2'b11 || rst_chip_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle got=%b/%b/%b want=1/11/0", except_req, except_code, rst_chip_o);
        end
        pulse_ack();
        pulse_done();
        sig_fit = 1'b0;
        @(negedge clk);
        $display("test_async_abort: done");
    endtask

    initial begin
        test_reset();
        test_pit_level();
        test_wd_fit();
        test_gating();
        test_rst_req();
        test_nest();
        test_async_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
